seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 108 ++++++++++
 tb/tb_seven_seg_scanner.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit seven-segment scanner: per slot a BLANK interval then a SHOW interval,
// with frame-coherent shadow copies of the digit values and enables.
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  digit_en,
    output logic [3:0]  anode,
    output logic [3:0]  nibble,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    typedef enum logic {BLANK, SHOW} state_t;

    localparam int PH_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
    localparam logic [PW-1:0] SHOW_LAST  = PW'(REFRESH_DIV - 1);

    state_t        state;
    logic [PW-1:0] phase;
    logic [15:0]   shadow_dig;
    logic [3:0]    shadow_en;

    logic          load_now;
    logic [15:0]   dig_eff;
    logic [3:0]    en_eff;
    logic [3:0]    strobe;

    function automatic logic [3:0] pick(input logic [15:0] v, input logic [1:0] i);
        case (i)
            2'd0:    pick = v[3:0];
            2'd1:    pick = v[7:4];
            2'd2:    pick = v[11:8];
            default: pick = v[15:12];
        endcase
    endfunction

    // The shadow load happens at the edge closing the first BLANK cycle of slot 0, so
    // anything registered on that same edge must see the freshly sampled inputs.
    always_comb begin
        load_now = (state == BLANK) && (digit_idx == 2'd0) && (phase == '0);
        dig_eff  = load_now ? digits   : shadow_dig;
        en_eff   = load_now ? digit_en : shadow_en;
        strobe   = ~(4'b0001 << digit_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK;
            phase      <= '0;
            digit_idx  <= '0;
            anode      <= '1;
            nibble     <= '0;
            frame_tick <= 1'b0;
            shadow_dig <= '0;
            shadow_en  <= '0;
        end else if (!enable) begin
            state      <= BLANK;
            phase      <= '0;
            digit_idx  <= '0;
            anode      <= '1;
            nibble     <= shadow_dig[3:0];
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (load_now) begin
                shadow_dig <= digits;
                shadow_en  <= digit_en;
            end
            case (state)
                BLANK: begin
                    nibble <= pick(dig_eff, digit_idx);
                    if (phase == BLANK_LAST) begin
                        state <= SHOW;
                        phase <= '0;
                        anode <= en_eff[digit_idx] ? strobe : 4'b1111;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                SHOW: begin
                    if (phase == SHOW_LAST) begin
                        state      <= BLANK;
                        phase      <= '0;
                        digit_idx  <= digit_idx + 2'd1;
                        anode      <= '1;
                        nibble     <= pick(shadow_dig, digit_idx + 2'd1);
                        frame_tick <= (digit_idx == 2'd3);
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    phase <= '0;
                    anode <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] digits = 16'h4321;
    logic [3:0]  digit_en = 4'b1111;
    logic [3:0]  anode;
    logic [3:0]  nibble;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits     (digits),
        .digit_en   (digit_en),
        .anode      (anode),
        .nibble     (nibble),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle k counted from the first BLANK cycle of slot 0: each slot is 2 blank + 4 show.
    function automatic logic [3:0] exp_anode(input int k, input logic [3:0] en);
        int p;
        int s;
        p = k % 24;
        s = p / 6;
        if ((p % 6) < 2 || !en[s]) return 4'b1111;
        return ~(4'b0001 << s);
    endfunction

    function automatic logic [3:0] exp_nib(input int k, input logic [15:0] d);
        int s;
        s = (k % 24) / 6;
        return 4'((d >> (4 * s)) & 16'hF);
    endfunction

    function automatic logic is_show(input int k);
        return ((k % 24) % 6) >= 2;
    endfunction

    task automatic restart();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        digits = 16'h4321;
        digit_en = 4'b1111;
        repeat (3) step();
        tests++; if (anode !== 4'b1111) begin fails++; $display("FAIL reset_anode got %b want 1111", anode); end
        tests++; if (nibble !== 4'h0) begin fails++; $display("FAIL reset_nibble got %h want 0", nibble); end
        tests++; if (digit_idx !== 2'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", digit_idx); end
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        reset = 1'b0;
    endtask

    task automatic test_basic_scan();
        digits = 16'h4321;
        digit_en = 4'b1111;
        restart();
        for (int k = 0; k < 49; k++) begin
            tests++; if (anode !== exp_anode(k, 4'b1111)) begin fails++; $display("FAIL scan_anode k=%0d got %b want %b", k, anode, exp_anode(k, 4'b1111)); end
            tests++; if (digit_idx !== 2'((k % 24) / 6)) begin fails++; $display("FAIL scan_idx k=%0d got %0d want %0d", k, digit_idx, (k % 24) / 6); end
            tests++; if (frame_tick !== (k % 24 == 0 && k > 0)) begin fails++; $display("FAIL scan_tick k=%0d got %b", k, frame_tick); end
            if (is_show(k)) begin
                tests++; if (nibble !== exp_nib(k, 16'h4321)) begin fails++; $display("FAIL scan_nibble k=%0d got %h want %h", k, nibble, exp_nib(k, 16'h4321)); end
            end
            step();
        end
    endtask

    task automatic test_tear_free();
        logic [15:0] want;
        digits = 16'h4321;
        digit_en = 4'b1111;
        restart();
        for (int k = 0; k < 48; k++) begin
            want = (k < 24) ? 16'h4321 : 16'hABCD;
            if (is_show(k)) begin
                tests++; if (nibble !== exp_nib(k, want)) begin fails++; $display("FAIL tear_nibble k=%0d got %h want %h", k, nibble, exp_nib(k, want)); end
                tests++; if (anode !== exp_anode(k, 4'b1111)) begin fails++; $display("FAIL tear_anode k=%0d got %b want %b", k, anode, exp_anode(k, 4'b1111)); end
            end
            if (k == 9) digits = 16'hABCD;
            step();
        end
    endtask

    task automatic test_suppress(input logic [3:0] en);
        digits = 16'h4321;
        digit_en = en;
        restart();
        for (int k = 0; k < 49; k++) begin
            tests++; if (anode !== exp_anode(k, en)) begin fails++; $display("FAIL suppress_anode en=%b k=%0d got %b want %b", en, k, anode, exp_anode(k, en)); end
            tests++; if (frame_tick !== (k % 24 == 0 && k > 0)) begin fails++; $display("FAIL suppress_tick en=%b k=%0d got %b", en, k, frame_tick); end
            step();
        end
        digit_en = 4'b1111;
    endtask

    task automatic test_enable_drop();
        digits = 16'h4321;
        digit_en = 4'b1111;
        restart();
        repeat (14) step();
        tests++; if (anode !== 4'b1011) begin fails++; $display("FAIL drop_pre_anode got %b want 1011", anode); end
        enable = 1'b0;
        step();
        tests++; if (anode !== 4'b1111) begin fails++; $display("FAIL drop_anode got %b want 1111", anode); end
        tests++; if (digit_idx !== 2'd0) begin fails++; $display("FAIL drop_idx got %0d want 0", digit_idx); end
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL drop_tick got %b want 0", frame_tick); end
        repeat (5) step();
        tests++; if (anode !== 4'b1111 || digit_idx !== 2'd0) begin fails++; $display("FAIL drop_parked anode %b idx %0d want 1111 0", anode, digit_idx); end
        enable = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tests++; if (anode !== exp_anode(k, 4'b1111)) begin fails++; $display("FAIL reen_anode k=%0d got %b want %b", k, anode, exp_anode(k, 4'b1111)); end
            tests++; if (frame_tick !== (k == 24)) begin fails++; $display("FAIL reen_tick k=%0d got %b", k, frame_tick); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        digits = 16'h4321;
        digit_en = 4'b1111;
        restart();
        repeat (20) step();
        tests++; if (anode !== 4'b0111) begin fails++; $display("FAIL rmid_pre_anode got %b want 0111", anode); end
        digits = 16'h5A6B;
        reset = 1'b1;
        step();
        tests++; if (anode !== 4'b1111) begin fails++; $display("FAIL rmid_anode got %b want 1111", anode); end
        tests++; if (digit_idx !== 2'd0) begin fails++; $display("FAIL rmid_idx got %0d want 0", digit_idx); end
        tests++; if (nibble !== 4'h0) begin fails++; $display("FAIL rmid_nibble got %h want 0", nibble); end
        reset = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tests++; if (anode !== exp_anode(k, 4'b1111)) begin fails++; $display("FAIL rmid_scan_anode k=%0d got %b want %b", k, anode, exp_anode(k, 4'b1111)); end
            tests++; if (frame_tick !== (k == 24)) begin fails++; $display("FAIL rmid_tick k=%0d got %b", k, frame_tick); end
            if (is_show(k)) begin
                tests++; if (nibble !== exp_nib(k, 16'h5A6B)) begin fails++; $display("FAIL rmid_nibble k=%0d got %h want %h", k, nibble, exp_nib(k, 16'h5A6B)); end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_tear_free();
        test_suppress(4'b0101);
        test_suppress(4'b0000);
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
